// File: rtl/conv_column_scheduler.sv
// Streams one frame of input columns from column memory into the conv layer,
// waiting out the kernel-load window first and counting pooled outputs until done.
module conv_column_scheduler #(
   parameter int DATA_WIDTH           = 16,
   parameter int INPUT_COL_SIZE       = 12,
   parameter int INPUT_CHANNEL_NUMBER = 4,
   parameter int NUM_COLS             = 12,
   parameter int KERNEL_SIZE          = 3
) (
   input  logic                                                               clk,
   input  logic                                                               rst,
   input  logic                                                               start,
   input  logic                                                               pause,
   output logic                                                               mem_rd_en,
   output logic [$clog2(NUM_COLS)-1:0]                                        mem_rd_addr,
   input  logic [INPUT_CHANNEL_NUMBER-1:0][INPUT_COL_SIZE-1:0][DATA_WIDTH-1:0] mem_rd_data,
   output logic [INPUT_CHANNEL_NUMBER-1:0][INPUT_COL_SIZE-1:0][DATA_WIDTH-1:0] conv_columns,
   output logic                                                               conv_valid_in,
   input  logic                                                               conv_valid_out,
   output logic                                                               busy,
   output logic                                                               done,
   output logic [$clog2(NUM_COLS):0]                                          out_count
);
   localparam int ADDR_W = $clog2(NUM_COLS);
   localparam int CNT_W  = ADDR_W + 1;
   localparam int WAIT_W = $clog2(KERNEL_SIZE + 1) + 1;
   localparam logic [CNT_W-1:0]  EXP       = CNT_W'((NUM_COLS - KERNEL_SIZE + 1) / 2);
   localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(NUM_COLS - 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(KERNEL_SIZE);

   typedef enum logic [2:0] {WAIT_LOAD, IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [ADDR_W-1:0]   col_cnt_q, col_cnt_d;
   logic [CNT_W-1:0]    out_count_q, out_count_d;
   logic                start_lat_q, start_lat_d;
   logic                mem_rd_en_q, mem_rd_en_d;
   logic [ADDR_W-1:0]   mem_rd_addr_q, mem_rd_addr_d;
   logic                conv_valid_in_q, conv_valid_in_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   always_comb begin
      state_d         = state_q;
      wait_cnt_d      = wait_cnt_q;
      col_cnt_d       = col_cnt_q;
      out_count_d     = out_count_q;
      start_lat_d     = start_lat_q;
      mem_rd_en_d     = 1'b0;
      mem_rd_addr_d   = mem_rd_addr_q;
      conv_valid_in_d = mem_rd_en_q;
      busy_d          = busy_q;
      done_d          = 1'b0;

      // Pooled outputs only count inside a frame and never run past the expected total.
      if (busy_q && conv_valid_out && (out_count_q < EXP)) begin
         out_count_d = out_count_q + CNT_W'(1);
      end

      case (state_q)
         WAIT_LOAD: begin
            if (start) begin
               start_lat_d = 1'b1;
            end
            if (wait_cnt_q == WAIT_LAST) begin
               state_d = IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         IDLE: begin
            if (start || start_lat_q) begin
               start_lat_d = 1'b0;
               col_cnt_d   = '0;
               out_count_d = '0;
               busy_d      = 1'b1;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            if (!pause) begin
               mem_rd_en_d   = 1'b1;
               mem_rd_addr_d = col_cnt_q;
               if (col_cnt_q == LAST_COL) begin
                  state_d = DRAIN;
               end else begin
                  col_cnt_d = col_cnt_q + ADDR_W'(1);
               end
            end
         end
         DRAIN: begin
            // Looking at the next count lets done follow the final pulse by one cycle.
            if (out_count_d == EXP) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = DONE;
            end
         end
         DONE: begin
            out_count_d = '0;
            state_d     = IDLE;
         end
         default: state_d = WAIT_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= WAIT_LOAD;
         wait_cnt_q      <= '0;
         col_cnt_q       <= '0;
         out_count_q     <= '0;
         start_lat_q     <= 1'b0;
         mem_rd_en_q     <= 1'b0;
         mem_rd_addr_q   <= '0;
         conv_valid_in_q <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         wait_cnt_q      <= wait_cnt_d;
         col_cnt_q       <= col_cnt_d;
         out_count_q     <= out_count_d;
         start_lat_q     <= start_lat_d;
         mem_rd_en_q     <= mem_rd_en_d;
         mem_rd_addr_q   <= mem_rd_addr_d;
         conv_valid_in_q <= conv_valid_in_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
      end
   end

   assign mem_rd_en     = mem_rd_en_q;
   assign mem_rd_addr   = mem_rd_addr_q;
   assign conv_valid_in = conv_valid_in_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign out_count     = out_count_q;
   assign conv_columns  = mem_rd_data;

endmodule

// File: doc/conv_column_scheduler.md
CONV_COLUMN_SCHEDULER -- requirements
Module: conv_column_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the word width of each feature value.
REQ-002 SHALL have parameter INPUT_COL_SIZE, default 12, the number of rows per input column.
REQ-003 SHALL have parameter INPUT_CHANNEL_NUMBER, default 4, the number of input channels delivered per column.
REQ-004 SHALL have parameter NUM_COLS, default 12, the number of input columns per frame.
REQ-005 SHALL have parameter KERNEL_SIZE, default 3, the convolution kernel width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous assert, active-low.
REQ-008 SHALL have port start, input, 1 bit: request to process one frame.
REQ-009 SHALL have port pause, input, 1 bit: when high, no new column read is issued.
REQ-010 SHALL have port mem_rd_en, output, 1 bit: column-memory read strobe.
REQ-011 SHALL have port mem_rd_addr, output, $clog2(NUM_COLS) bits: column index being read.
REQ-012 SHALL have port mem_rd_data, input, [INPUT_CHANNEL_NUMBER][INPUT_COL_SIZE] x DATA_WIDTH: read data, valid exactly 1 cycle after mem_rd_en.
REQ-013 SHALL have port conv_columns, output, same shape as mem_rd_data: column presented to the conv layer.
REQ-014 SHALL have port conv_valid_in, output, 1 bit: conv_columns valid this cycle.
REQ-015 SHALL have port conv_valid_out, input, 1 bit: pooled-column valid pulse from the conv layer.
REQ-016 SHALL have port busy, output, 1 bit: high from frame acceptance until done.
REQ-017 SHALL have port done, output, 1 bit: single-cycle pulse at frame completion.
REQ-018 SHALL have port out_count, output, $clog2(NUM_COLS)+1 bits: number of conv_valid_out pulses counted in the current frame.

Function
REQ-019 SHALL implement the states WAIT_LOAD, IDLE, ISSUE, DRAIN and DONE.
REQ-020 SHALL enter WAIT_LOAD on reset and remain there for exactly KERNEL_SIZE+1 cycles after rst deasserts, so that conv_valid_in never overlaps the conv layer's kernel-load window; it SHALL then move to IDLE.
REQ-021 SHALL latch a start received during WAIT_LOAD and begin that frame on entry to IDLE.
REQ-022 SHALL, in IDLE, when start is high (or latched), clear the column and output counters, assert busy, and move to ISSUE on the next cycle.
REQ-023 SHALL, in ISSUE with pause low, assert mem_rd_en with mem_rd_addr equal to the column counter, then increment the counter; addresses SHALL run 0..NUM_COLS-1 in order with no gaps or repeats.
REQ-024 SHALL, in ISSUE with pause high, hold mem_rd_en low and leave the column counter unchanged; a read issued in the previous cycle SHALL still complete.
REQ-025 SHALL move from ISSUE to DRAIN in the cycle after address NUM_COLS-1 is issued.
REQ-026 SHALL assert conv_valid_in exactly 1 cycle after each mem_rd_en, for exactly one cycle per read.
REQ-027 SHALL drive conv_columns combinationally from mem_rd_data (zero added latency).
REQ-028 SHALL increment out_count on each conv_valid_out while busy, saturating at EXP = (NUM_COLS-KERNEL_SIZE+1)/2; pulses received while not busy SHALL be ignored.
REQ-029 SHALL move from DRAIN to DONE when out_count reaches EXP, including when EXP is reached during ISSUE.
REQ-030 SHALL, in DONE, pulse done for one cycle, deassert busy in that same cycle, and return to IDLE.
REQ-031 SHALL ignore start while busy; it SHALL not be queued.
REQ-032 SHALL give pause no effect in DRAIN, DONE, IDLE or WAIT_LOAD.

Reset
REQ-033 SHALL, while rst is low, force: mem_rd_en=0, mem_rd_addr=0, conv_valid_in=0, busy=0, done=0, out_count=0, all counters 0, start latch cleared, state=WAIT_LOAD.
REQ-034 SHALL, on reset asserted mid-frame, abandon the frame with no done pulse, and rerun WAIT_LOAD after rst deasserts.

Verification
REQ-035 SHALL be verified by: start held high from reset release -> first mem_rd_en no earlier than cycle 6 after reset release; no conv_valid_in during cycles 0-3.
REQ-036 SHALL be verified by: start in IDLE, no pause, model returning 5 conv_valid_out pulses -> addresses 0..11 on consecutive cycles; 12 conv_valid_in pulses each lagging mem_rd_en by 1 cycle; done one cycle after the 5th pulse; busy falls with done.
REQ-037 SHALL be verified by: pause high for 3 cycles after address 4 -> addresses 0..11 with no gap or repeat, read 5 resumes after pause falls, and exactly 12 conv_valid_in pulses.
REQ-038 SHALL be verified by: start pulsed while busy, plus conv_valid_out while IDLE -> no second frame and out_count stays 0 in IDLE.
REQ-039 SHALL be verified by: rst low at address 7 -> all outputs 0 immediately, no done pulse; after release and a new start, reads begin at address 0.
